// File: rtl/pwm_output_gen.sv
// rtl/pwm_output_gen.sv - single-channel PWM with period-boundary double-buffered duty
module pwm_output_gen #(
    parameter int unsigned PRESCALE = 196
) (
    input  logic       clk_clk,
    input  logic       reset_reset_n,
    input  logic [7:0] duty_in,
    input  logic       enable,
    output logic       pwm_out,
    output logic       period_start,
    output logic [7:0] duty_active
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] pre;
    logic [7:0]    cnt;
    logic          run;
    logic          tick;
    logic          wrap;

    // The first enabled cycle only arms run, so a fresh period starts at cnt=0, pre=0.
    assign tick = run && (pre == PRE_LAST);
    assign wrap = tick && (cnt == 8'd254);

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            pre          <= '0;
            cnt          <= '0;
            run          <= 1'b0;
            duty_active  <= '0;
            pwm_out      <= 1'b0;
            period_start <= 1'b0;
        end else if (!enable) begin
            pre          <= '0;
            cnt          <= '0;
            run          <= 1'b0;
            duty_active  <= duty_in;
            pwm_out      <= 1'b0;
            period_start <= 1'b0;
        end else begin
            run          <= 1'b1;
            pwm_out      <= run && (cnt < duty_active);
            period_start <= !run || wrap;
            if (!run) begin
                pre <= '0;
                cnt <= '0;
            end else if (tick) begin
                pre <= '0;
                if (wrap) begin
                    cnt         <= 8'd0;
                    duty_active <= duty_in;
                end else begin
                    cnt <= cnt + 8'd1;
                end
            end else begin
                pre <= pre + PW'(1);
            end
        end
    end

endmodule
